vx_scoreboard_scalar: RTL and testbench
=======================================

// Module: vx_scoreboard_scalar
//
// PURPOSE
//  Per-issue-slot scalar scoreboard between the scalar ibuffer and the scalar operand-collect stage.
//  Tracks in-flight destination registers per warp and holds the head instruction until RAW and WAW hazards clear.
//  Releases the instruction through a one-entry output register, then clears pending bits on final (eop) writeback.
//  Also flags pending state for drain logic and a stall watchdog.
//
// PARAMETERS
//  ISSUE_RATIO    4       warps per issue slot; WIS_W = max(1, clog2(ISSUE_RATIO))
//  NR_BITS        6       register index width; NUM_REGS = 2**NR_BITS; index 0 = hardwired zero
//  PAYLOAD_W      128     opaque pass-through width (uuid, tmask, PC, ex/op/mod, imm, flags)
//  STALL_TIMEOUT  1024    consecutive blocked cycles before stall_timeout asserts (>=2)
//
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  in_valid       in   1          ibuffer head instruction valid
//  in_ready       out  1          head accepted this cycle
//  in_wis         in   WIS_W      warp index within slot
//  in_wb          in   1          instruction writes rd
//  in_rd          in   NR_BITS    destination register
//  in_rs1/2/3     in   NR_BITS    source registers (3 ports)
//  in_data        in   PAYLOAD_W  pass-through payload
//  out_valid      out  1          registered instruction to operand stage
//  out_ready      in   1          operand stage accepts
//  out_wis        out  WIS_W      registered in_wis
//  out_rs1/2/3    out  NR_BITS    registered sources
//  out_rd,out_wb  out  NR_BITS,1  registered rd / wb
//  out_data       out  PAYLOAD_W  registered payload
//  wb_valid       in   1          writeback beat
//  wb_wis         in   WIS_W      writeback warp
//  wb_rd          in   NR_BITS    writeback register
//  wb_eop         in   1          last beat of this writeback
//  pending_any    out  1          any pending bit set (registered)
//  stall_timeout  out  1          sticky watchdog flag
//
// BEHAVIOUR
//  - State: pending[ISSUE_RATIO][NUM_REGS] bit matrix, output register (valid + fields), 
//    stall counter (clog2(STALL_TIMEOUT+1) bits), and sticky timeout flag.
//  - Reset: pending all 0, out_valid=0, pending_any=0, stall_timeout=0, counter=0. 
//    out_* fields are don't-care while out_valid=0.
//  - Reset mid-operation drops any held instruction and all pending bits.
//    The bench issues no wb for pre-reset instructions.
//  - Hazard (combinational, from registered pending[in_wis] only):
//    hz = P[rs1] | P[rs2] | P[rs3] | (in_wb & P[rd]); the P[0] term is forced 0.
//  - No writeback bypass: a bit cleared at edge N unblocks evaluation in cycle N+1 at the earliest.
//  - in_ready = ~hz & (~out_valid | out_ready); independent of in_valid. Accept = in_valid & in_ready.
//  - On accept at edge N: out_* loaded from in_*, out_valid=1 from cycle N+1, so latency is 1 cycle.
//    pending[in_wis][in_rd] is set at N if in_wb & in_rd!=0.
//  - out_valid stays 1 until out_ready at an edge; back-to-back accept and drain gives full throughput.
//  - out_* hold stable while out_valid & ~out_ready.
//  - Writeback: wb_valid & wb_eop clears pending[wb_wis][wb_rd] at the edge.
//    Non-eop beats and wb_rd==0 have no effect.
//  - Same-edge set and clear on the same bit: the set wins. It cannot occur legally;
//    an assertion flags a clear of an unset bit.
//  - Same-edge set and clear on different bits: both apply.
//  - pending_any = OR of the next-state pending matrix, registered, so it is exact one cycle after the edge.
//  - Watchdog: counter increments when in_valid & ~in_ready, clears to 0 on accept or ~in_valid, saturates.
//    stall_timeout sets when the counter reaches STALL_TIMEOUT and clears only on reset.
//
// TESTING
//  1. Independent stream: 8 instr (warp0, rd=1..8, rs=0, wb=1), out_ready=1 
//     -> accepted 8 consecutive cycles; out_valid cycles 1..8; pending bits 1..8 set; pending_any=1.
//  2. RAW: A(w0,rd=5) accepted, then B(w0,rs2=5), wb(w0,rd=5,eop) at cycle 10 
//     -> B in_ready=0 through cycle 10, accepted cycle 11, out_valid cycle 12.
//  3. Cross-warp/non-eop: A(w1,rd=5) pending; B(w2,rs1=5) accepted immediately. 
//     wb(w1,rd=5,eop=0) leaves bit set; the following eop beat clears it.
//  4. Backpressure: out_ready=0 with out_valid=1 -> in_ready=0; out_* stable 20 cycles. 
//     out_ready=1 -> drain plus next accept in the same cycle.
//  5. Zero/WAW: rd=0 wb=1 never sets a bit; A(w0,rd=7) then B(w0,rd=7,wb=1) 
//     -> B blocked until wb(rd=7,eop).
//  6. Watchdog/reset: STALL_TIMEOUT=4, hazard held 4 cycles -> stall_timeout=1 and sticky. 
//     reset mid-stall -> all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/vx_scoreboard_scalar.sv
// Scalar scoreboard: holds the ibuffer head until RAW/WAW hazards on its
// warp clear, then releases it through a one-entry output register.
module vx_scoreboard_scalar #(
  parameter int ISSUE_RATIO   = 4,
  parameter int NR_BITS       = 6,
  parameter int PAYLOAD_W     = 128,
  parameter int STALL_TIMEOUT = 1024,
  localparam int WIS_W = (ISSUE_RATIO > 1) ? $clog2(ISSUE_RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIS_W-1:0]     in_wis,
  input  logic                 in_wb,
  input  logic [NR_BITS-1:0]   in_rd,
  input  logic [NR_BITS-1:0]   in_rs1,
  input  logic [NR_BITS-1:0]   in_rs2,
  input  logic [NR_BITS-1:0]   in_rs3,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIS_W-1:0]     out_wis,
  output logic [NR_BITS-1:0]   out_rs1,
  output logic [NR_BITS-1:0]   out_rs2,
  output logic [NR_BITS-1:0]   out_rs3,
  output logic [NR_BITS-1:0]   out_rd,
  output logic                 out_wb,
  output logic [PAYLOAD_W-1:0] out_data,
  input  logic                 wb_valid,
  input  logic [WIS_W-1:0]     wb_wis,
  input  logic [NR_BITS-1:0]   wb_rd,
  input  logic                 wb_eop,
  output logic                 pending_any,
  output logic                 stall_timeout
);

  localparam int NUM_REGS = 2 ** NR_BITS;
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);
  localparam logic [NUM_REGS-1:0] NZ_MASK =
    {{(NUM_REGS-1){1'b1}}, 1'b0};

  logic [ISSUE_RATIO-1:0][NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] pw;
  logic                hz;
  logic                accept;
  logic                set_en;
  logic                clr_en;
  logic                blocked;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                stall_q, stall_d;
  logic                pany_q;
  logic                out_valid_q;
  logic [WIS_W-1:0]    out_wis_q;
  logic [NR_BITS-1:0]  out_rs1_q;
  logic [NR_BITS-1:0]  out_rs2_q;
  logic [NR_BITS-1:0]  out_rs3_q;
  logic [NR_BITS-1:0]  out_rd_q;
  logic                out_wb_q;
  logic [PAYLOAD_W-1:0] out_data_q;

  // x0 never blocks, so its pending bit is masked off the lookup
  assign pw = pend_q[in_wis] & NZ_MASK;
  assign hz = pw[in_rs1] | pw[in_rs2] | pw[in_rs3]
            | (in_wb & pw[in_rd]);

  assign in_ready = ~hz & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign blocked  = in_valid & ~in_ready;
  assign set_en   = accept & in_wb & (in_rd != '0);
  assign clr_en   = wb_valid & wb_eop & (wb_rd != '0);

  // set is applied last so it wins on a same-bit collision
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[wb_wis][wb_rd] = 1'b0;
    if (set_en) pend_d[in_wis][in_rd] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    if (blocked) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    stall_d = stall_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      pany_q      <= 1'b0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pany_q  <= |pend_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      if (accept) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      out_wis_q  <= in_wis;
      out_rs1_q  <= in_rs1;
      out_rs2_q  <= in_rs2;
      out_rs3_q  <= in_rs3;
      out_rd_q   <= in_rd;
      out_wb_q   <= in_wb;
      out_data_q <= in_data;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_wis       = out_wis_q;
  assign out_rs1       = out_rs1_q;
  assign out_rs2       = out_rs2_q;
  assign out_rs3       = out_rs3_q;
  assign out_rd        = out_rd_q;
  assign out_wb        = out_wb_q;
  assign out_data      = out_data_q;
  assign pending_any   = pany_q;
  assign stall_timeout = stall_q;

  // an eop writeback must retire a register that is actually pending
  a_clr_set: assert property (
    @(posedge clk) disable iff (reset)
    clr_en |-> pend_q[wb_wis][wb_rd]
  );

endmodule

// File: tb/tb_vx_scoreboard_scalar.sv
// Randomized + directed bench for vx_scoreboard_scalar with a
// queue-based scoreboard and a behavioural hazard model.
module tb_vx_scoreboard_scalar;

  localparam int T = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_wis = '0;
  logic         in_wb = 1'b0;
  logic [5:0]   in_rd = '0;
  logic [5:0]   in_rs1 = '0;
  logic [5:0]   in_rs2 = '0;
  logic [5:0]   in_rs3 = '0;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [1:0]   out_wis;
  logic [5:0]   out_rs1;
  logic [5:0]   out_rs2;
  logic [5:0]   out_rs3;
  logic [5:0]   out_rd;
  logic         out_wb;
  logic [127:0] out_data;
  logic         wb_valid = 1'b0;
  logic [1:0]   wb_wis = '0;
  logic [5:0]   wb_rd = '0;
  logic         wb_eop = 1'b0;
  logic         pending_any;
  logic         stall_timeout;

  vx_scoreboard_scalar #(
    .ISSUE_RATIO(4), .NR_BITS(6),
    .PAYLOAD_W(128), .STALL_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wis(in_wis), .in_wb(in_wb), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wis(out_wis), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_rd(out_rd), .out_wb(out_wb), .out_data(out_data),
    .wb_valid(wb_valid), .wb_wis(wb_wis),
    .wb_rd(wb_rd), .wb_eop(wb_eop),
    .pending_any(pending_any), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   wis;
    logic [5:0]   rd;
    logic         wb;
    logic [5:0]   rs1;
    logic [5:0]   rs2;
    logic [5:0]   rs3;
    logic [127:0] data;
  } txn_t;

  txn_t exp_q[$];
  bit   pend [4][64];
  bit   m_full, m_any, m_stall, last_acc;
  int   m_cnt;
  int   checks = 0;
  int   failures = 0;

  function automatic void check(string name, logic [159:0] act,
                                logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL out_spurious actual=1 required=0");
      end else begin
        check("out_fields",
          {out_wis, out_rd, out_wb, out_rs1, out_rs2, out_rs3, out_data},
          exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  function automatic bit m_hz();
    bit h = 1'b0;
    if (in_rs1 != 0 && pend[in_wis][in_rs1]) h = 1'b1;
    if (in_rs2 != 0 && pend[in_wis][in_rs2]) h = 1'b1;
    if (in_rs3 != 0 && pend[in_wis][in_rs3]) h = 1'b1;
    if (in_wb && in_rd != 0 && pend[in_wis][in_rd]) h = 1'b1;
    return h;
  endfunction

  task automatic cycle();
    bit rdy;
    @(negedge clk);
    rdy = !m_hz() && (!m_full || out_ready);
    check("in_ready", 160'(in_ready), 160'(rdy));
    check("out_valid", 160'(out_valid), 160'(m_full));
    check("pending_any", 160'(pending_any), 160'(m_any));
    check("stall_timeout", 160'(stall_timeout), 160'(m_stall));
    @(posedge clk);
    last_acc = in_valid && rdy;
    if (last_acc)
      exp_q.push_back(txn_t'({in_wis, in_rd, in_wb,
                              in_rs1, in_rs2, in_rs3, in_data}));
    if (in_valid && !rdy) begin
      if (m_cnt < T) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    if (m_cnt >= T) m_stall = 1'b1;
    m_full = last_acc ? 1'b1 : (out_ready ? 1'b0 : m_full);
    if (wb_valid && wb_eop && wb_rd != 0) pend[wb_wis][wb_rd] = 1'b0;
    if (last_acc && in_wb && in_rd != 0) pend[in_wis][in_rd] = 1'b1;
    m_any = 1'b0;
    foreach (pend[i, j]) if (pend[i][j]) m_any = 1'b1;
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic set_in(bit v, int w, bit wb, int rd,
                        int r1, int r2, int r3);
    in_valid = v;
    in_wis   = 2'(w);
    in_wb    = wb;
    in_rd    = 6'(rd);
    in_rs1   = 6'(r1);
    in_rs2   = 6'(r2);
    in_rs3   = 6'(r3);
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_wb(int w, int rd, bit eop);
    wb_valid = 1'b1;
    wb_wis   = 2'(w);
    wb_rd    = 6'(rd);
    wb_eop   = eop;
  endtask

  task automatic wait_acc();
    last_acc = 1'b0;
    for (int i = 0; i < 64 && !last_acc; i++) cycle();
    if (!last_acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    in_valid = 1'b0;
  endtask

  task automatic issue(int w, bit wb, int rd, int r1, int r2, int r3);
    set_in(1'b1, w, wb, rd, r1, r2, r3);
    wait_acc();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (pend[i, j]) pend[i][j] = 1'b0;
    m_full  = 1'b0;
    m_any   = 1'b0;
    m_stall = 1'b0;
    m_cnt   = 0;
    exp_q.delete();
  endtask

  initial begin
    int pq[$];
    int k;
    do_reset();
    cycle();

    for (int i = 1; i <= 8; i++) begin
      set_in(1'b1, 0, 1'b1, i, 0, 0, 0);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    for (int i = 1; i <= 8; i++) begin
      set_wb(0, i, 1'b1);
      cycle();
    end
    cycle();

    issue(0, 1'b1, 5, 0, 0, 0);
    set_in(1'b1, 0, 1'b0, 0, 0, 5, 0);
    repeat (3) cycle();
    set_wb(0, 5, 1'b1);
    cycle();
    wait_acc();
    cycle();

    issue(1, 1'b1, 5, 0, 0, 0);
    issue(2, 1'b0, 0, 5, 0, 0);
    set_in(1'b1, 1, 1'b0, 0, 5, 0, 0);
    set_wb(1, 5, 1'b0);
    cycle();
    cycle();
    set_wb(1, 5, 1'b1);
    cycle();
    wait_acc();
    cycle();

    out_ready = 1'b0;
    issue(0, 1'b1, 10, 0, 0, 0);
    set_in(1'b1, 3, 1'b1, 11, 1, 2, 3);
    repeat (20) cycle();
    out_ready = 1'b1;
    wait_acc();
    cycle();

    issue(0, 1'b1, 0, 0, 0, 0);
    cycle();
    issue(0, 1'b1, 7, 0, 0, 0);
    set_in(1'b1, 0, 1'b1, 7, 0, 0, 0);
    repeat (3) cycle();
    set_wb(0, 7, 1'b1);
    cycle();
    wait_acc();
    cycle();

    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 7));
      pq.delete();
      foreach (pend[i, j]) if (pend[i][j]) pq.push_back(i * 64 + j);
      if (pq.size() != 0 && $urandom_range(0, 1) == 1) begin
        k = pq[$urandom_range(0, pq.size() - 1)];
        set_wb(k / 64, k % 64, $urandom_range(0, 2) != 0);
      end
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();

    do_reset();
    issue(0, 1'b1, 3, 0, 0, 0);
    set_in(1'b1, 0, 1'b0, 0, 3, 0, 0);
    repeat (6) cycle();
    in_valid = 1'b0;
    repeat (2) cycle();
    set_in(1'b1, 0, 1'b0, 0, 3, 0, 0);
    repeat (2) cycle();
    do_reset();
    cycle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
